// File: rtl/rr_priority_arbiter_pkg.sv
// ============================================================================
// Module   : arb_pkg
// Purpose  : Shared state type and default sizing for the round-robin arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int ARB_N     = 8;
  localparam int ARB_IDX_W = 3;

endpackage : arb_pkg

`default_nettype wire

// File: rtl/rr_priority_arbiter_prio_enc.sv
// ============================================================================
// Module   : prio_enc_n
// Purpose  : Combinational encoder returning the highest set bit index.
// Revision : 1.0
// ============================================================================
`default_nettype none

module prio_enc_n
  import arb_pkg::*;
#(
  parameter int N = ARB_N
) (
  input  logic [N-1:0]         vec_i,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 found_o
);

  localparam int IW = $clog2(N);

  // Ascending scan: the last set bit seen is the highest one.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vec_i[i]) begin
        idx_o   = IW'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule : prio_enc_n

`default_nettype wire

// File: rtl/rr_priority_arbiter.sv
// ============================================================================
// Module   : rr_priority_arbiter
// Purpose  : N-way arbiter, fixed or rotating priority, grant held until release.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_priority_arbiter
  import arb_pkg::*;
#(
  parameter int N      = ARB_N,
  parameter int ROTATE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 done,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_vld
);

  localparam int IW = $clog2(N);

  arb_state_t     state_q;
  logic [IW-1:0]  ptr_q;
  logic [IW-1:0]  idx_q;
  logic [N-1:0]   gnt_q;
  logic           vld_q;

  logic [IW-1:0]  shift_d;
  logic [N-1:0]   rot_d;
  logic [IW-1:0]  enc_idx_d;
  logic           found_d;
  logic [IW-1:0]  winner_d;
  logic           release_d;

  // Rotating left by (N-1-ptr) puts ptr at the MSB; N-1-ptr == ~ptr for N = 2^k.
  assign shift_d = ~ptr_q;

  always_comb begin
    rot_d = '0;
    for (int i = 0; i < N; i++) begin
      rot_d[i] = req[IW'(i) - shift_d];
    end
  end

  prio_enc_n #(
    .N (N)
  ) u_prio_enc (
    .vec_i   (rot_d),
    .idx_o   (enc_idx_d),
    .found_o (found_d)
  );

  assign winner_d  = enc_idx_d + ptr_q + IW'(1);
  assign release_d = done | ~req[idx_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '1;
      gnt_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found_d) begin
            state_q <= GRANT;
            gnt_q   <= {{(N-1){1'b0}}, 1'b1} << winner_d;
            idx_q   <= winner_d;
            vld_q   <= 1'b1;
          end
        end
        GRANT: begin
          if (release_d) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            // Previous owner drops to lowest priority.
            if (ROTATE != 0) begin
              ptr_q <= idx_q - IW'(1);
            end
          end
        end
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign gnt_vld = vld_q;

endmodule : rr_priority_arbiter

`default_nettype wire

// File: tb/tb_rr_priority_arbiter.sv
// ============================================================================
// Module   : tb_rr_priority_arbiter
// Purpose  : Directed vector table plus randomized model check of the arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rr_priority_arbiter;

  localparam int N = 8;

  typedef struct {
    bit         rst;
    logic [7:0] req;
    bit         done;
    logic [7:0] exp_gnt;
    logic [2:0] exp_idx;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req_r = '0;
  logic       done_r = 1'b0;
  logic [7:0] req_f = '0;
  logic       done_f = 1'b0;

  logic [7:0] gnt_r, gnt_f;
  logic [2:0] idx_r, idx_f;
  logic       vld_r, vld_f;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs[$];

  // Reference model: owner (-1 when idle) and priority pointer per DUT.
  int m_own[2];
  int m_ptr[2];

  always #5 clk = ~clk;

  rr_priority_arbiter #(.N(N), .ROTATE(1)) u_dut_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req_r),
    .done    (done_r),
    .gnt     (gnt_r),
    .gnt_idx (idx_r),
    .gnt_vld (vld_r)
  );

  rr_priority_arbiter #(.N(N), .ROTATE(0)) u_dut_fix (
    .clk     (clk),
    .rst     (rst),
    .req     (req_f),
    .done    (done_f),
    .gnt     (gnt_f),
    .gnt_idx (idx_f),
    .gnt_vld (vld_f)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [7:0] ag, input logic [2:0] ai,
                       input logic av, input logic [7:0] eg, input logic [2:0] ei);
    n_checks++;
    if ({ag, ai, av} !== {eg, ei, (|eg)}) begin
      n_fail++;
      $display("FAIL %s: got gnt=%h idx=%0d vld=%b, expected gnt=%h idx=%0d vld=%b",
               nm, ag, ai, av, eg, ei, (|eg));
    end
  endtask

  function automatic void add(input bit r, input logic [7:0] rq, input bit dn,
                              input logic [7:0] g, input logic [2:0] ix);
    vec_t v;
    v.rst = r; v.req = rq; v.done = dn; v.exp_gnt = g; v.exp_idx = ix;
    vecs.push_back(v);
  endfunction

  function automatic void model_step(input int d, input bit r, input logic [7:0] rq,
                                     input bit dn, input bit rot);
    if (r) begin
      m_own[d] = -1;
      m_ptr[d] = N - 1;
    end else if (m_own[d] < 0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr[d] - k + N) % N;
        if (rq[c]) begin
          m_own[d] = c;
          break;
        end
      end
    end else if (dn || !rq[m_own[d]]) begin
      if (rot) m_ptr[d] = (m_own[d] + N - 1) % N;
      m_own[d] = -1;
    end
  endfunction

  function automatic logic [7:0] m_gnt(input int d);
    logic [7:0] one;
    one = 8'd1;
    return (m_own[d] < 0) ? 8'h00 : (one << m_own[d]);
  endfunction

  function automatic logic [2:0] m_idx(input int d);
    return (m_own[d] < 0) ? 3'd0 : 3'(m_own[d]);
  endfunction

  initial begin
    // Reset with all requesting, then the first grant goes to 7.
    add(1, 8'hFF, 0, 8'h00, 3'd0);
    add(1, 8'hFF, 0, 8'h00, 3'd0);
    add(0, 8'hFF, 0, 8'h80, 3'd7);
    // Round-robin over all eight: 6,5,...,0, then wrap to 7.
    for (int i = 1; i <= 8; i++) begin
      add(0, 8'hFF, 1, 8'h00, 3'd0);
      add(0, 8'hFF, 0, 8'h80 >> (i % 8), 3'(7 - (i % 8)));
    end
    // Two requesters alternate.
    add(0, 8'h81, 1, 8'h00, 3'd0);
    add(0, 8'h81, 0, 8'h01, 3'd0);
    add(0, 8'h81, 1, 8'h00, 3'd0);
    add(0, 8'h81, 0, 8'h80, 3'd7);
    add(0, 8'h81, 1, 8'h00, 3'd0);
    add(0, 8'h81, 0, 8'h01, 3'd0);
    add(0, 8'h81, 1, 8'h00, 3'd0);
    // Single requester held four cycles, then released by done.
    for (int i = 0; i < 4; i++) add(0, 8'h04, 0, 8'h04, 3'd2);
    add(0, 8'h04, 1, 8'h00, 3'd0);
    // Owner 5 drops its request; ptr becomes 4.
    add(0, 8'h20, 0, 8'h20, 3'd5);
    add(0, 8'h00, 0, 8'h00, 3'd0);
    add(0, 8'h30, 0, 8'h10, 3'd4);
    // Non-owner request changes do not disturb the grant.
    add(0, 8'h1F, 0, 8'h10, 3'd4);
    add(0, 8'hFF, 0, 8'h10, 3'd4);
    add(0, 8'h10, 0, 8'h10, 3'd4);
    // Reset mid-grant restores ptr = 7.
    add(1, 8'hFF, 0, 8'h00, 3'd0);
    add(0, 8'hFF, 0, 8'h80, 3'd7);
    add(0, 8'hFF, 1, 8'h00, 3'd0);
    // done in IDLE is ignored, including on the grant edge.
    add(0, 8'h00, 1, 8'h00, 3'd0);
    add(0, 8'h00, 1, 8'h00, 3'd0);
    add(0, 8'h02, 1, 8'h02, 3'd1);
    add(0, 8'h02, 1, 8'h00, 3'd0);
    // done and request drop together: ptr moves only once (to 2).
    add(0, 8'h08, 0, 8'h08, 3'd3);
    add(0, 8'h00, 1, 8'h00, 3'd0);
    add(0, 8'hFF, 0, 8'h04, 3'd2);
    // Owner 0 release wraps ptr to 7.
    add(0, 8'h01, 1, 8'h00, 3'd0);
    add(0, 8'h01, 0, 8'h01, 3'd0);
    add(0, 8'h01, 1, 8'h00, 3'd0);
    add(0, 8'hFF, 0, 8'h80, 3'd7);

    foreach (vecs[i]) begin
      rst    = vecs[i].rst;
      req_r  = vecs[i].req;
      done_r = vecs[i].done;
      tick();
      check($sformatf("vec%0d", i), gnt_r, idx_r, vld_r, vecs[i].exp_gnt, vecs[i].exp_idx);
      check($sformatf("fix_idle%0d", i), gnt_f, idx_f, vld_f, 8'h00, 3'd0);
    end

    // Fixed priority: repeated grants always go to the top requester.
    rst = 1'b0; req_r = '0; done_r = 1'b0;
    req_f = 8'hFF; done_f = 1'b0;
    for (int r = 0; r < 3; r++) begin
      tick(); check("fix_ff_grant", gnt_f, idx_f, vld_f, 8'h80, 3'd7);
      done_f = 1'b1;
      tick(); check("fix_ff_release", gnt_f, idx_f, vld_f, 8'h00, 3'd0);
      done_f = 1'b0;
    end
    req_f = 8'h06;
    for (int r = 0; r < 3; r++) begin
      tick(); check("fix_06_grant", gnt_f, idx_f, vld_f, 8'h04, 3'd2);
      done_f = 1'b1;
      tick(); check("fix_06_release", gnt_f, idx_f, vld_f, 8'h00, 3'd0);
      done_f = 1'b0;
    end

    // Randomized run of both variants against the reference model.
    rst = 1'b1;
    model_step(0, 1'b1, req_r, done_r, 1'b1);
    model_step(1, 1'b1, req_f, done_f, 1'b0);
    tick();
    check("rand_reset_rr", gnt_r, idx_r, vld_r, m_gnt(0), m_idx(0));
    check("rand_reset_fix", gnt_f, idx_f, vld_f, m_gnt(1), m_idx(1));
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(79) == 0);
      if ($urandom_range(2) == 0) req_r = 8'($urandom);
      if ($urandom_range(2) == 0) req_f = 8'($urandom);
      done_r = ($urandom_range(3) == 0);
      done_f = ($urandom_range(3) == 0);
      model_step(0, rst, req_r, done_r, 1'b1);
      model_step(1, rst, req_f, done_f, 1'b0);
      tick();
      check("rand_rr", gnt_r, idx_r, vld_r, m_gnt(0), m_idx(0));
      check("rand_fix", gnt_f, idx_f, vld_f, m_gnt(1), m_idx(1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_rr_priority_arbiter

`default_nettype wire

// File: doc/rr_priority_arbiter.md
# rr_priority_arbiter

Eight-way arbiter that shares a single resource between requesters, using priority encoding to choose the winner. Supports fixed priority (highest index wins) or rotating round-robin priority. A winner's grant is registered and held until the owner releases it. It sits between the requester bank and the shared resource, and also drives the encoded owner index to the resource's mux select.

## Interface
- `N`, default 8: number of requesters; power of two, ≥ 2.
- `ROTATE`, default 1: 1 = round-robin priority; 0 = fixed priority (bit N-1 highest).
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req`, in, N: per-requester request level.
- `done`, in, 1: owner releases the resource; sampled only while a grant is active.
- `gnt`, out, N: one-hot grant, or all zeros; registered.
- `gnt_idx`, out, $clog2(N): encoded index of the owner; registered.
- `gnt_vld`, out, 1: a grant is active; equals |gnt.

## Operation
- Two states: IDLE and GRANT.
- Priority pointer `ptr` ($clog2(N) bits) names the highest-priority index.
  - Search order is ptr, ptr-1, …, 0, N-1, …, ptr+1 (descending, with wrap).
- **IDLE**
  - req == 0: stay in IDLE; outputs stay zero.
  - req != 0: the winner k is the first set bit in search order. Next edge: enter GRANT, gnt = 1<<k, gnt_idx = k, gnt_vld = 1.
- **GRANT**
  - Hold gnt, gnt_idx and gnt_vld constant.
  - Release when done == 1 or req[gnt_idx] == 0, whichever comes first.
  - On release, next edge: enter IDLE and clear all outputs to 0.
  - If ROTATE = 1, ptr = (gnt_idx - 1) mod N at the release edge, so the previous owner becomes lowest priority.
- ROTATE = 0: ptr is constant at N-1, which gives pure priority-encoder behaviour.
- done while in IDLE is ignored.
- Changes to req by non-owners during GRANT are ignored; no preemption.
- Arbitration happens only in IDLE, so there is a mandatory one-cycle bubble between consecutive grants.
- Wrap-around: after owner 0 releases, ptr = N-1.
- gnt_idx arithmetic is modulo N; no saturation.

## Timing
- Reset values: state = IDLE, ptr = N-1, gnt = 0, gnt_idx = 0, gnt_vld = 0.
- Request to grant: req seen in IDLE at edge t → gnt visible after edge t (one cycle latency).
- Release: done or req drop seen at edge t → gnt = 0 after edge t. Earliest next grant is after edge t+1.
- rst has priority over every event. rst during GRANT clears the grant and ptr at that edge, with no release handshake; the owner must re-request.
- All outputs are registered; no combinational path from req or done to any output.
- done and req drop in the same cycle: a single release, with the ptr update applied once.

## Structure
- Package `arb_pkg`:
  - `typedef enum logic {IDLE, GRANT} arb_state_t`
  - localparam defaults `ARB_N = 8`, `ARB_IDX_W = 3`
- Sub-module `prio_enc_n`, parameterised width N:
  - Combinational; returns the index of the highest set bit plus a found flag, which is 0 when the input is zero.
  - The arbiter rotates req left by (N-1-ptr), so ptr maps to bit N-1.
  - The arbiter encodes the rotated vector, then restores the index with winner = (enc_idx + ptr + 1) mod N.
- Top level: the state register, ptr register, output registers and release detection.

## Test plan
1. **Reset:** rst = 1 for 2 cycles with req = 8'hFF → gnt = 0, gnt_idx = 0, gnt_vld = 0. First edge after rst deasserts → gnt = 8'h80, gnt_idx = 7.
2. **Single requester:** req = 8'h04 in cycle t → gnt = 8'h04, gnt_idx = 2 from t+1. done pulse at t+5 → gnt = 0 at t+6.
3. **Round-robin fairness (ROTATE = 1):**
   - req = 8'hFF constant, done pulsed in the first GRANT cycle of each grant.
   - Owners are 7, 6, 5, 4, 3, 2, 1, 0, 7, with exactly one idle cycle between grants.
   - Repeat with req = 8'h81 → owners alternate 7, 0, 7.
4. **Fixed priority (ROTATE = 0):** req = 8'hFF with repeated done → owner is always 7. req = 8'h06 → owner is always 2.
5. **Release by request drop:** owner 5 drops req[5] without done → gnt = 0 next cycle, ptr = 4. With req = 8'h30 the next owner is 4.
6. **Corner cases:**
   - rst asserted mid-grant → outputs zero next cycle and ptr = 7.
   - done asserted in IDLE → no effect.
   - Non-owner req toggling during GRANT → gnt unchanged.
